// File: rtl/ecc_ram_pipelined_pkg.sv
// Elaboration-time helpers for the SECDED codeword layout: check-bit count,
// codeword width, and which Hamming positions carry data versus check bits.
package ecc_pkg;

    localparam int MASK_W = 128;

    function automatic int ecc_check_bits(input int dw);
        int p = 0;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    function automatic int ecc_cw_width(input int dw);
        return dw + ecc_check_bits(dw) + 1;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Data bit index held at a non-power-of-two Hamming position.
    function automatic int data_index(input int pos);
        int n = 0;
        for (int k = 1; k < pos; k++) begin
            if (!is_pow2(k)) n++;
        end
        return n;
    endfunction

    function automatic logic [MASK_W-1:0] check_mask(input int cw, input int j);
        logic [MASK_W-1:0] m = '0;
        for (int k = 1; k < cw; k++) begin
            if (((k >> j) & 1) != 0) m = m | (MASK_W'(1) << k);
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_ram_pipelined_secded_codec.sv
// Combinational Hamming SECDED encoder and decoder. Bit 0 is overall parity,
// check bits sit at power-of-two positions, data fills the rest LSB first.
module secded_codec
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int P          = ecc_check_bits(DATA_WIDTH),
    localparam int CW         = ecc_cw_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] enc_data,
    output logic [CW-1:0]         enc_cw,
    input  logic [CW-1:0]         dec_cw,
    output logic [DATA_WIDTH-1:0] dec_data,
    output logic [CW-1:0]         dec_cor_cw,
    output logic                  dec_sbe,
    output logic                  dec_dbe
);

    localparam logic [P-1:0] MAX_POS = P'(CW - 1);

    logic [CW-1:1] w_place;
    logic [CW-1:1] w_ham;
    logic [CW-1:1] w_fix;
    logic [P-1:0]  w_chk;
    logic [P-1:0]  w_syn;
    logic          w_ovr;

    for (genvar gi = 0; gi < P; gi++) begin : g_chk
        localparam logic [MASK_W-1:0] MASK = check_mask(CW, gi);
        assign w_chk[gi] = ^(w_place & MASK[CW-1:1]);
        // Mask covers the stored check bit too, so this is recomputed ^ stored.
        assign w_syn[gi] = ^(dec_cw[CW-1:1] & MASK[CW-1:1]);
    end

    for (genvar gi = 1; gi < CW; gi++) begin : g_pos
        if (is_pow2(gi)) begin : g_check_pos
            assign w_place[gi] = 1'b0;
            assign w_ham[gi]   = w_chk[$clog2(gi)];
        end else begin : g_data_pos
            assign w_place[gi]               = enc_data[data_index(gi)];
            assign w_ham[gi]                 = w_place[gi];
            assign dec_data[data_index(gi)]  = w_fix[gi];
        end
        assign w_fix[gi] = dec_cw[gi] ^ (dec_sbe & (w_syn == P'(gi)));
    end

    assign w_ovr   = ^dec_cw;
    assign dec_sbe = w_ovr & (w_syn <= MAX_POS);
    assign dec_dbe = (~w_ovr & (w_syn != '0)) | (w_ovr & (w_syn > MAX_POS));

    assign enc_cw     = {w_ham, ^w_ham};
    assign dec_cor_cw = {w_fix, ^w_fix};

endmodule

// File: rtl/ecc_ram_pipelined.sv
// SECDED-protected single-port RAM with a two-stage read pipeline,
// single-bit write-back scrubbing and saturating error counters.
module ecc_ram_pipelined
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int ADDR_WIDTH   = 4,
    parameter  int AUTO_CORRECT = 1,
    parameter  int COUNT_WIDTH  = 16,
    localparam int CW           = ecc_cw_width(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    input  logic [CW-1:0]          req_inject,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_sbe,
    output logic                   rsp_dbe,
    input  logic                   clr_counts,
    output logic [COUNT_WIDTH-1:0] sbe_count,
    output logic [COUNT_WIDTH-1:0] dbe_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit WB_EN = (AUTO_CORRECT != 0);

    logic [CW-1:0]          r_mem [DEPTH];
    logic [CW-1:0]          r_s1_cw;
    logic                   r_s1_valid;
    logic [ADDR_WIDTH-1:0]  r_s1_addr;
    logic [COUNT_WIDTH-1:0] r_sbe_cnt;
    logic [COUNT_WIDTH-1:0] r_dbe_cnt;

    logic [CW-1:0]          w_enc_cw;
    logic [CW-1:0]          w_cor_cw;
    logic [DATA_WIDTH-1:0]  w_dec_data;
    logic                   w_sbe;
    logic                   w_dbe;
    logic                   w_accept;
    logic                   w_wb;
    logic                   w_sbe_hit;
    logic                   w_dbe_hit;

    secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_codec (
        .enc_data   (req_wdata),
        .enc_cw     (w_enc_cw),
        .dec_cw     (r_s1_cw),
        .dec_data   (w_dec_data),
        .dec_cor_cw (w_cor_cw),
        .dec_sbe    (w_sbe),
        .dec_dbe    (w_dbe)
    );

    // The write-back steals the single port for one cycle.
    assign w_wb      = r_s1_valid & w_sbe & WB_EN;
    assign req_ready = ~w_wb;
    assign w_accept  = req_valid & req_ready;
    assign w_sbe_hit = r_s1_valid & w_sbe;
    assign w_dbe_hit = r_s1_valid & w_dbe;

    always_ff @(posedge clk) begin
        if (w_wb) begin
            r_mem[r_s1_addr] <= w_cor_cw;
        end else if (w_accept && req_we) begin
            r_mem[req_addr] <= w_enc_cw ^ req_inject;
        end
        if (w_accept && !req_we) begin
            r_s1_cw <= r_mem[req_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_sbe    <= 1'b0;
            rsp_dbe    <= 1'b0;
        end else begin
            r_s1_valid <= w_accept & ~req_we;
            if (w_accept) begin
                r_s1_addr <= req_addr;
            end
            rsp_valid <= r_s1_valid;
            rsp_sbe   <= w_sbe_hit;
            rsp_dbe   <= w_dbe_hit;
            if (r_s1_valid) begin
                rsp_rdata <= w_dec_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sbe_cnt <= '0;
            r_dbe_cnt <= '0;
        end else if (clr_counts) begin
            r_sbe_cnt <= '0;
            r_dbe_cnt <= '0;
        end else begin
            if (w_sbe_hit && r_sbe_cnt != '1) r_sbe_cnt <= r_sbe_cnt + COUNT_WIDTH'(1);
            if (w_dbe_hit && r_dbe_cnt != '1) r_dbe_cnt <= r_dbe_cnt + COUNT_WIDTH'(1);
        end
    end

    assign sbe_count = r_sbe_cnt;
    assign dbe_count = r_dbe_cnt;

endmodule

// File: tb/tb_ecc_ram_pipelined.sv
// Directed bench for ecc_ram_pipelined (8-bit data, 13-bit codeword, 2-bit
// counters so saturation is reachable); inputs change and outputs are read on negedges.
module tb_ecc_ram_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic [12:0] req_inject;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_sbe;
    logic        rsp_dbe;
    logic        clr_counts;
    logic [1:0]  sbe_count;
    logic [1:0]  dbe_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  b2b_data [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
    logic [12:0] b2b_inj  [4] = '{13'h0008, 13'h1000, 13'h0080, 13'h0100};

    always #5 clk = ~clk;

    ecc_ram_pipelined #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (4),
        .AUTO_CORRECT (1),
        .COUNT_WIDTH  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_inject (req_inject),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_sbe    (rsp_sbe),
        .rsp_dbe    (rsp_dbe),
        .clr_counts (clr_counts),
        .sbe_count  (sbe_count),
        .dbe_count  (dbe_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input logic we, input logic [3:0] addr, input logic [7:0] d,
                         input logic [12:0] inj);
        int waited = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = d;
        req_inject = inj;
        while (req_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_inject = '0;
        $display("txn %s addr=%0d wdata=%02h inject=%04h", we ? "WR" : "RD", addr, d, inj);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] addr, input logic [7:0] d,
                            input logic sbe, input logic dbe);
        issue(1'b0, addr, 8'h00, 13'h0000);
        check({tag, ".ready_s1"}, {31'b0, req_ready}, {31'b0, !sbe});
        check({tag, ".latency"}, {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, ".rdata"}, {24'b0, rsp_rdata}, {24'b0, d});
        check({tag, ".sbe"}, {31'b0, rsp_sbe}, {31'b0, sbe});
        check({tag, ".dbe"}, {31'b0, rsp_dbe}, {31'b0, dbe});
        check({tag, ".ready_after"}, {31'b0, req_ready}, 32'd1);
        $display("rsp %s addr=%0d rdata=%02h sbe=%0b dbe=%0b", tag, addr, rsp_rdata, rsp_sbe, rsp_dbe);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nrsp;
        int cyc;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_inject = '0;
        clr_counts = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset.rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
        check("reset.rsp_sbe", {31'b0, rsp_sbe}, 32'd0);
        check("reset.rsp_dbe", {31'b0, rsp_dbe}, 32'd0);
        check("reset.sbe_count", {30'b0, sbe_count}, 32'd0);
        check("reset.dbe_count", {30'b0, dbe_count}, 32'd0);
        check("reset.req_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Read in flight when reset hits must never produce a response.
        issue(1'b1, 4'd3, 8'hA5, 13'h0000);
        issue(1'b0, 4'd3, 8'h00, 13'h0000);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_mid.req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid.sbe_count", {30'b0, sbe_count}, 32'd0);
        check("rst_mid.dbe_count", {30'b0, dbe_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid.no_late_rsp", {31'b0, rsp_valid}, 32'd0);

        read_chk("clean", 4'd3, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        check("clean.pulse_end", {31'b0, rsp_valid}, 32'd0);

        issue(1'b1, 4'd5, 8'h3C, 13'h0010);
        read_chk("sbe", 4'd5, 8'h3C, 1'b1, 1'b0);
        check("sbe.sbe_count", {30'b0, sbe_count}, 32'd1);
        read_chk("sbe_reread", 4'd5, 8'h3C, 1'b0, 1'b0);
        check("sbe_reread.sbe_count", {30'b0, sbe_count}, 32'd1);

        issue(1'b1, 4'd2, 8'h11, 13'h0001);
        read_chk("parity", 4'd2, 8'h11, 1'b1, 1'b0);
        check("parity.sbe_count", {30'b0, sbe_count}, 32'd2);

        issue(1'b1, 4'd7, 8'h5A, 13'h0006);
        read_chk("dbe", 4'd7, 8'h5A, 1'b0, 1'b1);
        check("dbe.dbe_count", {30'b0, dbe_count}, 32'd1);
        check("dbe.sbe_count", {30'b0, sbe_count}, 32'd2);
        read_chk("dbe_reread", 4'd7, 8'h5A, 1'b0, 1'b1);
        check("dbe_reread.dbe_count", {30'b0, dbe_count}, 32'd2);

        clr_counts = 1'b1;
        @(negedge clk);
        clr_counts = 1'b0;
        check("clr.sbe_count", {30'b0, sbe_count}, 32'd0);
        check("clr.dbe_count", {30'b0, dbe_count}, 32'd0);

        // Four single-bit errors read with req_valid held high throughout.
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 4'(8 + i), b2b_data[i], b2b_inj[i]);
        end
        acc  = 0;
        nrsp = 0;
        cyc  = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd8;
        while ((acc < 4 || nrsp < 4) && cyc < 40) begin
            if (rsp_valid === 1'b1) begin
                if (nrsp < 4) begin
                    check("b2b.rdata", {24'b0, rsp_rdata}, {24'b0, b2b_data[nrsp]});
                    check("b2b.sbe", {31'b0, rsp_sbe}, 32'd1);
                    $display("rsp b2b #%0d rdata=%02h sbe=%0b", nrsp, rsp_rdata, rsp_sbe);
                end
                nrsp++;
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                acc++;
                @(posedge clk);
                #1;
                if (acc == 4) req_valid = 1'b0;
                else          req_addr  = 4'(8 + acc);
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        check("b2b.accepted", acc, 32'd4);
        check("b2b.responses", nrsp, 32'd4);
        check("b2b.sbe_count_sat", {30'b0, sbe_count}, 32'd3);

        // Clear lands on the same edge that registers a new sbe response.
        issue(1'b1, 4'd12, 8'h77, 13'h0200);
        issue(1'b0, 4'd12, 8'h00, 13'h0000);
        clr_counts = 1'b1;
        @(negedge clk);
        clr_counts = 1'b0;
        check("clr_hit.rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("clr_hit.rsp_sbe", {31'b0, rsp_sbe}, 32'd1);
        check("clr_hit.rdata", {24'b0, rsp_rdata}, 32'h77);
        check("clr_hit.sbe_count", {30'b0, sbe_count}, 32'd0);
        check("clr_hit.dbe_count", {30'b0, dbe_count}, 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ecc_ram_pipelined.md
# ecc_ram_pipelined

Single-port synchronous RAM that protects every stored word with a parametrised Hamming SECDED code. Reads run through a two-stage pipeline with a valid/ready request handshake. Single-bit errors are corrected in the returned data and, optionally, written back to the array. Saturating error counters feed the status block, and a per-write injection mask lets the bench and firmware self-test exercise the code.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per word (≥ 4)
- ADDR_WIDTH, 4: depth = 2**ADDR_WIDTH words
- AUTO_CORRECT, 1: 1 = write corrected codeword back on single-bit error
- COUNT_WIDTH, 16: width of each error counter
- Derived: P = smallest p with 2**p ≥ DATA_WIDTH+p+1; CW = DATA_WIDTH+P+1 (8→13, 32→39)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at rising edge
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_inject  in  CW  XOR mask applied to encoded codeword before storing (writes only)
- rsp_valid  out  1  one-cycle pulse per accepted read
- rsp_rdata  out  DATA_WIDTH  corrected read data
- rsp_sbe  out  1  single-bit error detected and corrected
- rsp_dbe  out  1  uncorrectable error
- clr_counts  in  1  synchronous clear of both counters
- sbe_count  out  COUNT_WIDTH  saturating count of rsp_sbe pulses
- dbe_count  out  COUNT_WIDTH  saturating count of rsp_dbe pulses

## Operation
- Codeword layout:
  - bit 0 = overall parity over bits 1..CW-1.
  - Bits 1..CW-1 are Hamming positions; check bits sit at power-of-two positions.
  - Data fills the remaining positions in ascending order, data LSB first.
- Encode (writes): even parity per check bit. Stored word = encode(req_wdata) ^ req_inject.
- Decode:
  - syndrome S = P-bit recomputed-check XOR stored-check; overall mismatch O.
  - S=0, O=0: clean.
  - O=1, S=0: sbe, error in bit 0, data unaffected.
  - O=1, 0<S≤CW-1: sbe, flip bit S.
  - O=0, S≠0: dbe.
  - O=1, S>CW-1: dbe.
- dbe: rsp_rdata = raw uncorrected data bits; no write-back.
- sbe with AUTO_CORRECT=1: corrected codeword (including regenerated bit 0) is written to the same address.
- Pipeline:
  - Stage 1 holds s1_valid, s1_addr and the array read codeword.
  - Stage 2 registers the decode results into the rsp_* outputs.
- Handshake:
  - req_ready = ~(s1_valid & s1_sbe & AUTO_CORRECT); it is low only in the cycle the write-back occupies the port.
  - Writes produce no response.
- Counters:
  - Each increments by 1 when its flag is registered high, saturating at all ones.
  - clr_counts in the same cycle as an increment → result is 0.
- Array contents are not reset. Reading a never-written address gives undefined data and flags.

## Timing
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_sbe=0, rsp_dbe=0.
  - sbe_count=0, dbe_count=0, s1_valid=0.
  - req_ready=1 (combinationally, since s1_valid=0).
- Read accepted at edge N:
  - Array is read at edge N.
  - Response is registered at edge N+1, so rsp_valid is high for the cycle N+1..N+2.
  - Latency is 2 edges. Throughput is one read per cycle.
- Write accepted at edge N: array is updated at edge N. A read accepted at N+1 returns the new data.
- Write-back: occurs at edge N+1, the same edge that registers the response. No request is accepted at N+1, so no write/write-back ordering hazard exists.
- rsp_sbe and rsp_dbe are valid only with rsp_valid and are 0 otherwise.
- Reset mid-operation: the in-flight read is dropped (no rsp_valid) and any pending write-back is abandoned.

## Structure
- Package ecc_pkg:
  - function ecc_check_bits(DATA_WIDTH) returning P.
  - codeword-width helper.
  - is_pow2 position helper used for the layout.
- Sub-module secded_codec:
  - purely combinational, parametrised by DATA_WIDTH.
  - encode port: data → codeword.
  - decode port: codeword → corrected data, corrected codeword, sbe, dbe.
- Top: array, stage-1/stage-2 registers, ready logic, counters.

## Test plan
Directed scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, CW=13:
- Reset: assert rst mid-read → rsp_valid=0, both counts 0, req_ready=1. No response appears for the dropped read.
- Clean path: write 0xA5 to addr 3, read addr 3 → rsp_valid two edges after acceptance, rdata=0xA5, sbe=0, dbe=0.
- Single-bit error: write 0x3C to addr 5 with inject=13'h0010, then read 5 → rdata=0x3C, sbe=1, req_ready low one cycle, sbe_count=1. Re-reading 5 → sbe=0 (written back).
- Parity-bit error: write 0x11 to addr 2 with inject=13'h0001, read → rdata=0x11, sbe=1.
- Double-bit error: write 0x5A to addr 7 with inject=13'h0006, read → dbe=1, sbe=0, dbe_count=1. Re-reading 7 → dbe=1 again, dbe_count=2.
- Back-to-back and saturation, with COUNT_WIDTH=2:
  - Four consecutive reads of four addresses each injected with an sbe → sbe_count=3 (saturated), responses one per accepted read.
  - clr_counts coincident with a new sbe response → count 0.
